dijkstra_relax_unit: RTL

//  Nios II multi-cycle custom instruction plus Avalon-MM write slave for one Dijkstra relaxation step.
//  The CPU streams edge weights into an internal FIFO over Avalon.
//  The instruction then gives an edge count (dataa) and a base distance (datab).
//  It returns either min(base+weight) or the index of that minimum.

---
 rtl/dijkstra_relax_unit_if.sv | 25 ++
 rtl/dijkstra_relax_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dijkstra_relax_unit_if.sv
// rtl/dijkstra_relax_unit_if.sv - custom-instruction and Avalon write-slave signal bundle
interface dijkstra_relax_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              clk_en;
    logic              start;
    logic [31:0]       dataa;
    logic [DATA_W-1:0] datab;
    logic              n;
    logic [31:0]       result;
    logic              done;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;

    modport master (
        output clk_en, start, dataa, datab, n, write, writedata,
        input  result, done, waitrequest
    );

    modport slave (
        input  clk_en, start, dataa, datab, n, write, writedata,
        output result, done, waitrequest
    );
endinterface

// File: rtl/dijkstra_relax_unit.sv
// rtl/dijkstra_relax_unit.sv - buffered saturating min/argmin relaxation step
module dijkstra_relax_unit #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    dijkstra_relax_unit_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] INF = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t r_state;
    state_t w_next_state;

    // Weight FIFO: one extra pointer bit distinguishes full from empty.
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    // Instruction operands and running minimum.
    logic [31:0]       r_cnt;
    logic [DATA_W-1:0] r_base;
    logic              r_sel;
    logic [31:0]       r_i;
    logic [DATA_W-1:0] r_min;
    logic [31:0]       r_idx;
    logic [31:0]       r_result;

    logic              w_accept;
    logic              w_done;
    logic [DATA_W:0]   w_sum_full;
    logic [DATA_W-1:0] w_sum;
    logic              w_better;
    logic [DATA_W-1:0] w_new_min;
    logic [31:0]       w_new_idx;
    logic              w_last;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (w_level == '0);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Stall the master while full, and while in reset so nothing lands in a flushing FIFO.
    assign bus.waitrequest = w_full | reset;
    assign w_push          = bus.write & ~bus.waitrequest;

    // An INF weight means "no edge" and must never wrap into a small distance.
    assign w_sum_full = {1'b0, r_base} + {1'b0, w_head};
    assign w_sum      = ((w_head == INF) || w_sum_full[DATA_W]) ? INF : w_sum_full[DATA_W-1:0];
    assign w_better   = (w_sum < r_min);
    assign w_new_min  = w_better ? w_sum : r_min;
    assign w_new_idx  = w_better ? r_i : r_idx;
    assign w_last     = (r_i == r_cnt - 32'd1);

    assign bus.done   = w_done;
    assign bus.result = r_result;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, pop and done decode; every move waits for clk_en.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clk_en && bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.dataa == 32'd0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.clk_en && !w_empty) begin
                    w_pop = 1'b1;
                    if (w_last) begin
                        w_next_state = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (bus.clk_en) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FIFO storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.writedata;
        end
    end

    // FIFO pointers; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Operand latch, running min/argmin, and result capture as FIN is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_base   <= '0;
            r_sel    <= 1'b0;
            r_i      <= '0;
            r_min    <= INF;
            r_idx    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt  <= bus.dataa;
            r_base <= bus.datab;
            r_sel  <= bus.n;
            r_i    <= '0;
            r_min  <= INF;
            r_idx  <= '0;
            if (bus.dataa == 32'd0) begin
                r_result <= bus.n ? 32'd0 : 32'(INF);
            end
        end else if (w_pop) begin
            r_min <= w_new_min;
            r_idx <= w_new_idx;
            r_i   <= r_i + 32'd1;
            if (w_last) begin
                r_result <= r_sel ? w_new_idx : 32'(w_new_min);
            end
        end
    end
endmodule
